// File: rtl/press_pkg.sv
// Shared types and default timing for the press decoder slice.
// Counter sizing helper keeps the decoder and its testbench consistent.
package press_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HOLD   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } press_state_t;

  localparam int unsigned LONG_CYCLES_DEF   = 32'd64;
  localparam int unsigned GAP_CYCLES_DEF    = 32'd32;
  localparam int unsigned REPEAT_CYCLES_DEF = 32'd16;

  // Width of a counter that must reach (largest threshold - 1), at least 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    else m = m;
    if (c > m) m = c;
    else m = m;
    if ($clog2(m) < 1) return 32'd1;
    else return $clog2(m);
  endfunction

endpackage

// File: rtl/level_edge.sv
// Edge detector for the debounced button level. The history register resets
// to 1 so a button already held when reset releases produces no rise.
module level_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic prev_level_r;

  // Previous-level history register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_level_r <= 1'b1;
    else       prev_level_r <= level;
  end

  assign rise = level & ~prev_level_r;
  assign fall = ~level & prev_level_r;

endmodule

// File: rtl/press_decoder.sv
// Classifies a debounced button level into one-shot short, double, long and
// auto-repeat event pulses using one shared cycle counter.
module press_decoder
  import press_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES    = GAP_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  localparam int unsigned CNT_W = cnt_width(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);

  press_state_t     state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             rise_s, fall_s;
  logic             short_s, double_s, long_s, repeat_s;
  logic             short_r, double_r, long_r, repeat_r, busy_r;

  level_edge u_level_edge (
    .clk   (clk),
    .reset (reset),
    .level (btn_level),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  // State, counter and registered event outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      short_r  <= 1'b0;
      double_r <= 1'b0;
      long_r   <= 1'b0;
      repeat_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      short_r  <= short_s;
      double_r <= double_s;
      long_r   <= long_s;
      repeat_r <= repeat_s;
      busy_r   <= (state_next_s != IDLE);
    end
  end

  // Next-state selection; edges take priority over counter thresholds.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (rise_s) state_next_s = PRESS1;
        else        state_next_s = IDLE;
      end
      PRESS1: begin
        if (fall_s)                  state_next_s = GAP;
        else if (cnt_r == LONG_LAST) state_next_s = HOLD;
        else                         state_next_s = PRESS1;
      end
      HOLD: begin
        if (fall_s) state_next_s = IDLE;
        else        state_next_s = HOLD;
      end
      GAP: begin
        if (rise_s)                 state_next_s = PRESS2;
        else if (cnt_r == GAP_LAST) state_next_s = IDLE;
        else                        state_next_s = GAP;
      end
      PRESS2: begin
        if (fall_s) state_next_s = IDLE;
        else        state_next_s = PRESS2;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Event pulses and counter update; the counter clears on every state entry.
  always_comb begin
    short_s    = 1'b0;
    double_s   = 1'b0;
    long_s     = 1'b0;
    repeat_s   = 1'b0;
    cnt_next_s = cnt_r;
    case (state_r)
      IDLE: cnt_next_s = CNT_ZERO;
      PRESS1: begin
        if (fall_s) cnt_next_s = CNT_ZERO;
        else if (cnt_r == LONG_LAST) begin
          long_s     = 1'b1;
          cnt_next_s = CNT_ZERO;
        end else cnt_next_s = cnt_r + CNT_ONE;
      end
      HOLD: begin
        if (fall_s) cnt_next_s = CNT_ZERO;
        else if (cnt_r == REPEAT_LAST) begin
          repeat_s   = 1'b1;
          cnt_next_s = CNT_ZERO;
        end else cnt_next_s = cnt_r + CNT_ONE;
      end
      GAP: begin
        if (rise_s) cnt_next_s = CNT_ZERO;
        else if (cnt_r == GAP_LAST) begin
          short_s    = 1'b1;
          cnt_next_s = CNT_ZERO;
        end else cnt_next_s = cnt_r + CNT_ONE;
      end
      PRESS2: begin
        if (fall_s) begin
          double_s   = 1'b1;
          cnt_next_s = CNT_ZERO;
        end else cnt_next_s = cnt_r;
      end
      default: cnt_next_s = CNT_ZERO;
    endcase
  end

  assign short_press  = short_r;
  assign double_press = double_r;
  assign long_press   = long_r;
  assign repeat_pulse = repeat_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_press_decoder.sv
// Directed bench for press_decoder with LONG=8, GAP=5, REPEAT=4; event
// cycle numbers are compared against hand-computed edge offsets.
module tb_press_decoder;

  logic clk = 1'b0;
  logic reset;
  logic btn_level;
  logic short_press, double_press, long_press, repeat_pulse, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_short, n_double, n_long, n_rep, n_multi;
  int short_cyc, double_cyc, long_cyc, rep_first, rep_last;
  int fdet, rdet;

  press_decoder #(
    .LONG_CYCLES   (8),
    .GAP_CYCLES    (5),
    .REPEAT_CYCLES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_level    (btn_level),
    .short_press  (short_press),
    .double_press (double_press),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_short = 0; n_double = 0; n_long = 0; n_rep = 0;
    short_cyc = -1; double_cyc = -1; long_cyc = -1; rep_first = -1; rep_last = -1;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic steps(input int n);
    int hot;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      hot = int'(short_press) + int'(double_press) + int'(long_press) + int'(repeat_pulse);
      if (hot > 1) n_multi++;
      if (short_press)  begin n_short++;  short_cyc  = cyc; end
      if (double_press) begin n_double++; double_cyc = cyc; end
      if (long_press)   begin n_long++;   long_cyc   = cyc; end
      if (repeat_pulse) begin
        if (n_rep == 0) rep_first = cyc;
        n_rep++;
        rep_last = cyc;
      end
    end
  endtask

  function automatic int all_pulses();
    return n_short + n_double + n_long + n_rep;
  endfunction

  function automatic int out_vec();
    return {28'd0, short_press, double_press, long_press, repeat_pulse};
  endfunction

  initial begin
    n_multi = 0;
    clear_counts();
    reset = 1'b1;
    btn_level = 1'b0;
    steps(2);
    check_eq("reset_pulses", out_vec(), 0);
    check_eq("reset_busy", int'(busy), 0);
    reset = 1'b0;
    steps(3);
    check_eq("idle_busy", int'(busy), 0);

    // 1: short press
    clear_counts();
    btn_level = 1'b1; steps(1);
    check_eq("s1_busy_press", int'(busy), 1);
    steps(2);
    btn_level = 1'b0; fdet = cyc + 1;
    steps(20);
    check_eq("s1_short_count", n_short, 1);
    check_eq("s1_short_cycle", short_cyc, fdet + 5);
    check_eq("s1_other_pulses", n_double + n_long + n_rep, 0);
    check_eq("s1_busy_after", int'(busy), 0);

    // 2: double press
    clear_counts();
    btn_level = 1'b1; steps(3);
    btn_level = 1'b0; steps(2);
    btn_level = 1'b1; steps(3);
    btn_level = 1'b0; fdet = cyc + 1;
    steps(20);
    check_eq("s2_double_count", n_double, 1);
    check_eq("s2_double_cycle", double_cyc, fdet);
    check_eq("s2_no_short", n_short, 0);

    // 3: long press with auto-repeat
    clear_counts();
    btn_level = 1'b1; rdet = cyc + 1;
    steps(20);
    btn_level = 1'b0;
    steps(10);
    check_eq("s3_long_count", n_long, 1);
    check_eq("s3_long_cycle", long_cyc, rdet + 8);
    check_eq("s3_repeat_count", n_rep, 2);
    check_eq("s3_repeat_first", rep_first, rdet + 12);
    check_eq("s3_repeat_last", rep_last, rdet + 16);
    check_eq("s3_no_short_double", n_short + n_double, 0);
    check_eq("s3_busy_after", int'(busy), 0);

    // 4: second rise lands exactly on the gap-timeout edge
    clear_counts();
    btn_level = 1'b1; steps(3);
    btn_level = 1'b0; fdet = cyc + 1;
    steps(5);
    check_eq("s4_rise_edge_offset", cyc + 1, fdet + 5);
    btn_level = 1'b1; steps(3);
    btn_level = 1'b0; fdet = cyc + 1;
    steps(20);
    check_eq("s4_no_short", n_short, 0);
    check_eq("s4_double_count", n_double, 1);
    check_eq("s4_double_cycle", double_cyc, fdet);

    // 5: button held across reset release is ignored
    clear_counts();
    reset = 1'b1; btn_level = 1'b1;
    steps(2);
    reset = 1'b0;
    steps(20);
    check_eq("s5_held_no_pulse", all_pulses(), 0);
    check_eq("s5_held_busy", int'(busy), 0);
    btn_level = 1'b0; steps(5);
    check_eq("s5_release_no_pulse", all_pulses(), 0);
    btn_level = 1'b1; steps(3);
    btn_level = 1'b0; fdet = cyc + 1;
    steps(20);
    check_eq("s5_short_count", n_short, 1);
    check_eq("s5_short_cycle", short_cyc, fdet + 5);

    // 6a: reset in GAP discards the pending short press
    clear_counts();
    btn_level = 1'b1; steps(3);
    btn_level = 1'b0; steps(3);
    check_eq("s6_gap_busy_before", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check_eq("s6_gap_busy_async", int'(busy), 0);
    check_eq("s6_gap_pulses_async", out_vec(), 0);
    steps(2);
    reset = 1'b0;
    steps(20);
    check_eq("s6_gap_no_short", n_short, 0);

    // 6b: reset in HOLD while long_press is high
    clear_counts();
    btn_level = 1'b1; steps(9);
    check_eq("s6_hold_long_high", int'(long_press), 1);
    #1 reset = 1'b1;
    #1;
    check_eq("s6_hold_pulses_async", out_vec(), 0);
    check_eq("s6_hold_busy_async", int'(busy), 0);
    steps(2);
    reset = 1'b0;
    steps(12);
    btn_level = 1'b0;
    steps(10);
    check_eq("s6_hold_no_repeat", n_rep, 0);
    check_eq("s6_hold_single_long", n_long, 1);
    check_eq("s6_hold_no_short_double", n_short + n_double, 0);

    check_eq("one_hot_pulses", n_multi, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
